// File: rtl/bit_serial_add_sub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell is stepped LSB first over WIDTH cycles.
// A start/done handshake wraps each operation; the result and flags hold until the next completion.
module bit_serial_add_sub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-2:0] sh_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s, fa_c, c_msb, last_bit;
  logic [WIDTH-1:0] r_next;

  // The single full-adder cell, written out at gate level.
  assign fa_s     = sh_a[0] ^ sh_b[0] ^ carry;
  assign fa_c     = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
  assign c_msb    = carry;
  assign r_next   = {fa_s, sh_r};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
            sh_a  <= a;
            sh_b  <= op_sub ? ~b : b;
            carry <= op_sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          sh_r  <= r_next[WIDTH-1:1];
          carry <= fa_c;
          if (last_bit) begin
            cnt      <= '0;
            result   <= r_next;
            c_out    <= fa_c;
            overflow <= c_msb ^ fa_c;
            zero     <= (r_next == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_add_sub_ctrl.sv
// Directed and randomised self-checking bench for bit_serial_add_sub_ctrl at WIDTH=8.
module tb_bit_serial_add_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, overflow, zero;
  logic [W-1:0] result;

  int           tests_run = 0;
  int           tests_failed = 0;
  logic [W-1:0] held_result = '0;

  bit_serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Waits for done with a cycle budget, checking that result holds while busy.
  task automatic waitDone(input string tag, output int cycles);
    bit stable = 1'b1;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1 && result !== held_result) stable = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, " result stable while busy"}, 32'(stable), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic sub, input logic [W-1:0] va,
                               input logic [W-1:0] vb, input logic [W-1:0] er,
                               input logic ec, input logic ev, input logic ez);
    int cycles;
    @(negedge clk);
    start = 1'b1; op_sub = sub; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~va; b = ~vb; op_sub = ~sub;
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    waitDone(tag, cycles);
    checkOutput({tag, " latency"}, cycles, 8);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " result"}, 32'(result), 32'(er));
    checkOutput({tag, " c_out"}, 32'(c_out), 32'(ec));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(ev));
    checkOutput({tag, " zero"}, 32'(zero), 32'(ez));
    held_result = er;
    @(posedge clk); #1;
    checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
    checkOutput({tag, " result held in idle"}, 32'(result), 32'(er));
  endtask

  initial begin
    int cycles;
    int done_seen;
    logic [W:0]   full;
    logic [W-1:0] ra, rb, rr;
    logic         rs, rv;

    #2;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset flags", {29'd0, c_out, overflow, zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("add 35+4A", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0);
    applyStimulus("add 7F+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus("add FF+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    applyStimulus("sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);

    // start held high; operands change mid-run and must only affect the next op.
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 8'h35; b = 8'h4A;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1; a = 8'hFF; b = 8'hFF; op_sub = 1'b1;
    waitDone("held start op1", cycles);
    checkOutput("held start op1 latency", cycles, 5);
    checkOutput("held start op1 result", 32'(result), 32'h7F);
    held_result = 8'h7F;
    @(posedge clk); #1;
    checkOutput("held start done width", 32'(done), 32'd0);
    checkOutput("held start idle not busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("held start op2 accepted", 32'(busy), 32'd1);
    waitDone("held start op2", cycles);
    checkOutput("held start op2 latency", cycles, 8);
    checkOutput("held start op2 result", 32'(result), 32'h00);
    checkOutput("held start op2 flags", {29'd0, c_out, overflow, zero}, 32'b101);
    held_result = 8'h00;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    checkOutput("held start op2 done width", 32'(done), 32'd0);

    // Reset in the middle of a run aborts it and clears held outputs.
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort result", 32'(result), 32'd0);
    checkOutput("abort flags", {29'd0, c_out, overflow, zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    held_result = '0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    checkOutput("abort no done", done_seen, 0);
    applyStimulus("after abort 12+34", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      full = rs ? ({1'b0, ra} + {1'b0, ~rb} + 9'd1) : ({1'b0, ra} + {1'b0, rb});
      rr = full[W-1:0];
      rv = rs ? ((ra[W-1] != rb[W-1]) && (rr[W-1] != ra[W-1]))
              : ((ra[W-1] == rb[W-1]) && (rr[W-1] != ra[W-1]));
      applyStimulus($sformatf("rand %0d %s %0h,%0h", i, rs ? "sub" : "add", ra, rb),
                    rs, ra, rb, rr, full[W], rv, (rr == '0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
